// File: rtl/gpio_pkg.sv
// gpio_pkg: register-map offsets and byte-enable helpers shared by the GPIO slave.
package gpio_pkg;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_SET     = 3'd1;
  localparam logic [2:0] GPIO_CLR     = 3'd2;
  localparam logic [2:0] GPIO_DIR     = 3'd3;
  localparam logic [2:0] GPIO_IN      = 3'd4;
  localparam logic [2:0] GPIO_EDGE    = 3'd5;
  localparam logic [2:0] GPIO_RISE_EN = 3'd6;
  localparam logic [2:0] GPIO_FALL_EN = 3'd7;

  localparam int GPIO_WINDOW_BYTES = 32;

  function automatic logic [31:0] wmask_bits(input logic [3:0] wmask);
    logic [31:0] bits;
    for (int k = 0; k < 4; k++) bits[8*k +: 8] = {8{wmask[k]}};
    return bits;
  endfunction

  function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wmask);
    logic [31:0] bits;
    bits = wmask_bits(wmask);
    return (old_val & ~bits) | (new_val & bits);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: one-bit stability filter, only present when GPIO_DEBOUNCE_EN is defined.
// The output follows the input once it has disagreed for DEB_CYCLES consecutive clocks.
`ifdef GPIO_DEBOUNCE_EN
module gpio_debounce_bit #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_filt
);

  localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Any cycle where the input agrees with the filtered value restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (i_sync == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_filt <= i_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_filt = r_filt;

endmodule
`endif

// File: rtl/gpio_port_n.sv
// gpio_port_n: bus-slave GPIO with per-bit direction, set/clear, synced inputs and edge irq.
// Define GPIO_DEBOUNCE_EN to insert a DEB_CYCLES stability filter after the synchroniser.
module gpio_port_n
  import gpio_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  input  logic             ren,
  input  logic             wen,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             active,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  output logic             irq
);

  logic [WIDTH-1:0] r_out, r_dir, r_edge, r_riseEn, r_fallEn;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [31:0]      r_rdata;
  logic             r_ready, r_irq;

  logic             w_active, w_wr, w_rd;
  logic [2:0]       w_off;
  logic [31:0]      w_wdBits, w_merged, w_rdNext;
  logic [WIDTH-1:0] w_filt, w_rise, w_fall, w_w1c;
  logic [WIDTH-1:0] w_outNext, w_dirNext, w_riseNext, w_fallNext;

  // 33-bit compare so a window at the top of the address space cannot wrap.
  assign w_active = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, addr} <  ({1'b0, BASE_ADDR} + 33'(GPIO_WINDOW_BYTES)));
  assign w_off    = addr[4:2];
  assign w_wr     = wen & w_active;
  assign w_rd     = ren & w_active;
  assign w_wdBits = wdata & wmask_bits(wmask);

`ifdef GPIO_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    gpio_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sync (r_sync2[g]),
      .o_filt (w_filt[g])
    );
  end
`else
  assign w_filt = r_sync2;
`endif

  assign w_rise = w_filt & ~r_prev & r_riseEn;
  assign w_fall = ~w_filt & r_prev & r_fallEn;

  always_comb begin
    w_merged   = '0;
    w_outNext  = r_out;
    w_dirNext  = r_dir;
    w_riseNext = r_riseEn;
    w_fallNext = r_fallEn;
    w_w1c      = '0;
    if (w_wr) begin
      case (w_off)
        GPIO_OUT: begin
          w_merged  = apply_wmask(32'(r_out), wdata, wmask);
          w_outNext = w_merged[WIDTH-1:0];
        end
        GPIO_SET: w_outNext = r_out | w_wdBits[WIDTH-1:0];
        GPIO_CLR: w_outNext = r_out & ~w_wdBits[WIDTH-1:0];
        GPIO_DIR: begin
          w_merged  = apply_wmask(32'(r_dir), wdata, wmask);
          w_dirNext = w_merged[WIDTH-1:0];
        end
        GPIO_EDGE: w_w1c = w_wdBits[WIDTH-1:0];
        GPIO_RISE_EN: begin
          w_merged   = apply_wmask(32'(r_riseEn), wdata, wmask);
          w_riseNext = w_merged[WIDTH-1:0];
        end
        GPIO_FALL_EN: begin
          w_merged   = apply_wmask(32'(r_fallEn), wdata, wmask);
          w_fallNext = w_merged[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdNext = '0;
    case (w_off)
      GPIO_OUT:     w_rdNext = 32'(r_out);
      GPIO_DIR:     w_rdNext = 32'(r_dir);
      GPIO_IN:      w_rdNext = 32'(w_filt);
      GPIO_EDGE:    w_rdNext = 32'(r_edge);
      GPIO_RISE_EN: w_rdNext = 32'(r_riseEn);
      GPIO_FALL_EN: w_rdNext = 32'(r_fallEn);
      default:      w_rdNext = '0;
    endcase
  end

  // Edge capture ORs in after the clear so a same-cycle hardware edge survives a W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_edge   <= '0;
      r_riseEn <= '0;
      r_fallEn <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_out    <= w_outNext;
      r_dir    <= w_dirNext;
      r_riseEn <= w_riseNext;
      r_fallEn <= w_fallNext;
      r_edge   <= (r_edge & ~w_w1c) | w_rise | w_fall;
      r_sync1  <= io_in;
      r_sync2  <= r_sync1;
      r_prev   <= w_filt;
      r_rdata  <= w_rd ? w_rdNext : 32'h0;
      r_ready  <= (ren | wen) & w_active;
      r_irq    <= |r_edge;
    end
  end

  assign active = w_active;
  assign rdata  = r_rdata;
  assign ready  = r_ready;
  assign io_out = r_out;
  assign io_oe  = r_dir;
  assign irq    = r_irq;

endmodule
